// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART image loader.
// ioaddr register selects, ASCII digit base and the loader FSM state encoding.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam logic [7:0] ASCII_BASE = 8'h30;

    typedef enum logic [2:0] {
        ST_INIT_LO = 3'd0,
        ST_INIT_HI = 3'd1,
        ST_HUNT    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_HOLD    = 3'd4
    } ldr_state_e;

    // Classification digit 0..9 to its ASCII character.
    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_BASE + {4'h0, d};
    endfunction

endpackage

// File: rtl/spart_bus_seq.sv
// SPART processor-bus sequencer: single-cycle strobes with a mandatory idle
// cycle after each, fixed priority cfg > tx > rx, and the databus tristate.
//
// Handshake: every *_req is a level. A *_gnt in cycle N means the strobe is
// on the bus in cycle N+1; the requester must advance or drop its request on
// the cycle it sees the grant. Read data is captured on the edge that ends
// the read strobe and is presented with rd_vld for exactly one cycle.
module spart_bus_seq
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_q_full,
    input  logic       rx_q_empty,
    input  logic       cfg_req,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    input  logic       rd_req,
    output logic       cfg_gnt,
    output logic       tx_gnt,
    output logic       rd_gnt,
    output logic       rd_busy,
    output logic       rd_vld,
    output logic [7:0] rd_data,
    output logic       iocs_n,
    output logic       iorw_n,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    logic       rd_strobe;
    logic       drv_en;
    logic [7:0] wdata;
    logic       bus_free;
    logic       tx_ok;

    // Arbitration: launch only when the bus is idle this cycle (enforces the gap).
    always_comb begin
        bus_free = iocs_n;
        tx_ok    = tx_req && !tx_q_full;
        cfg_gnt  = bus_free && cfg_req;
        tx_gnt   = bus_free && !cfg_req && tx_ok;
        rd_gnt   = bus_free && !cfg_req && !tx_ok && rd_req && !rx_q_empty;
    end

    // Strobe register: a grant becomes a one-cycle bus access next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iocs_n    <= 1'b1;
            iorw_n    <= 1'b1;
            ioaddr    <= ADDR_BUF;
            drv_en    <= 1'b0;
            wdata     <= 8'h00;
            rd_strobe <= 1'b0;
        end else begin
            iocs_n    <= !(cfg_gnt || tx_gnt || rd_gnt);
            iorw_n    <= !(cfg_gnt || tx_gnt);
            ioaddr    <= cfg_gnt ? cfg_addr : ADDR_BUF;
            drv_en    <= cfg_gnt || tx_gnt;
            wdata     <= cfg_gnt ? cfg_data : (tx_gnt ? tx_data : 8'h00);
            rd_strobe <= rd_gnt;
        end
    end

    // Read capture: the FIFO head is already on the bus during the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rd_vld <= rd_strobe;
            if (rd_strobe) begin
                rd_data <= databus;
            end
        end
    end

    assign databus = drv_en ? wdata : 8'hzz;
    assign rd_busy = rd_strobe || rd_vld;

endmodule

// File: rtl/spart_img_loader.sv
// SPART image loader: pulls framed 28x28 pixel images from the SPART RX queue
// into the image buffer and returns classification digits through SPART TX.
// Build option: SPART_IMG_BAUD_INIT_EN makes reset start with the two baud
// divisor writes; without it the loader starts hunting for a header at once.
module spart_img_loader
    import spart_pkg::*;
#(
    parameter logic [12:0] BAUD_DIV = 13'h01B2,
    parameter int          NUM_PIX  = 784,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int          TIMEOUT  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       iocs_n,
    output logic       iorw_n,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       tx_q_full,
    input  logic       rx_q_empty,
    output logic       img_we,
    output logic [9:0] img_addr,
    output logic [7:0] img_wdata,
    output logic       frame_rdy,
    input  logic       frame_ack,
    input  logic       result_vld,
    input  logic [3:0] result,
    output logic       frame_err
);

    localparam int              TO_W     = 22;
    localparam logic [9:0]      LAST_PIX = 10'(NUM_PIX - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX   = '1;

`ifdef SPART_IMG_BAUD_INIT_EN
    localparam ldr_state_e RESET_STATE = ST_INIT_LO;
`else
    localparam ldr_state_e RESET_STATE = ST_HUNT;
`endif

    ldr_state_e      state, state_nxt;
    logic [9:0]      pix_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            pend_vld;
    logic [3:0]      pend_dig;

    logic            cfg_req, cfg_gnt, tx_req, tx_gnt, rd_req, rd_gnt;
    logic [1:0]      cfg_addr;
    logic [7:0]      cfg_data, tx_data, rd_data;
    logic            rd_busy, rd_vld;
    logic            is_hdr;
    logic [10:0]     pix_claimed;

    spart_bus_seq u_bus (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_q_full  (tx_q_full),
        .rx_q_empty (rx_q_empty),
        .cfg_req    (cfg_req),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .rd_req     (rd_req),
        .cfg_gnt    (cfg_gnt),
        .tx_gnt     (tx_gnt),
        .rd_gnt     (rd_gnt),
        .rd_busy    (rd_busy),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .iocs_n     (iocs_n),
        .iorw_n     (iorw_n),
        .ioaddr     (ioaddr),
        .databus    (databus)
    );

    assign is_hdr      = rd_data == HDR_BYTE;
    assign to_hit      = to_cnt >= TO_LIMIT;
    // Pixels already stored plus the one read still on its way in.
    assign pix_claimed = {1'b0, pix_cnt} + {10'b0, rd_busy};

    // A fresh result goes straight to the sequencer so the write can follow next cycle.
    assign tx_req  = pend_vld || result_vld;
    assign tx_data = ascii_digit(result_vld ? result : pend_dig);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT_LO: if (cfg_gnt) state_nxt = ST_INIT_HI;
            ST_INIT_HI: if (cfg_gnt) state_nxt = ST_HUNT;
            ST_HUNT:    if (rd_vld && is_hdr) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (rd_vld && pix_cnt == LAST_PIX) state_nxt = ST_HOLD;
                else if (!rd_vld && to_hit)        state_nxt = ST_HUNT;
            end
            ST_HOLD:    if (frame_ack) state_nxt = ST_HUNT;
            default:    state_nxt = RESET_STATE;
        endcase
    end

    // Output decode: bus requests and image-side strobes.
    always_comb begin
        cfg_req   = (state == ST_INIT_LO) || (state == ST_INIT_HI);
        cfg_addr  = (state == ST_INIT_HI) ? ADDR_DBH : ADDR_DBL;
        cfg_data  = (state == ST_INIT_HI) ? {3'b000, BAUD_DIV[12:8]} : BAUD_DIV[7:0];
        rd_req    = 1'b0;
        if (state == ST_HUNT)      rd_req = 1'b1;
        else if (state == ST_LOAD) rd_req = pix_claimed < 11'(NUM_PIX);
        img_we    = (state == ST_LOAD) && rd_vld;
        frame_rdy = state == ST_HOLD;
        frame_err = (state == ST_LOAD) && !rd_vld && to_hit;
    end

    assign img_addr  = pix_cnt;
    assign img_wdata = rd_data;

    // Pixel counter: cleared on the header, stops at the last pixel index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= 10'd0;
        end else if (state == ST_HUNT && rd_vld && is_hdr) begin
            pix_cnt <= 10'd0;
        end else if (state == ST_LOAD && rd_vld && pix_cnt != LAST_PIX) begin
            pix_cnt <= pix_cnt + 10'd1;
        end
    end

    // Inter-pixel timeout counter, live only in LOAD, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  to_cnt <= '0;
        else if (state != ST_LOAD)   to_cnt <= '0;
        else if (rd_vld)             to_cnt <= '0;
        else if (to_cnt != TO_MAX)   to_cnt <= to_cnt + 1'b1;
    end

    // One-entry pending result; a newer result overwrites an unsent one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_dig <= 4'd0;
        end else if (tx_gnt) begin
            pend_vld <= 1'b0;
        end else if (result_vld) begin
            pend_vld <= 1'b1;
            pend_dig <= result;
        end
    end

endmodule

// File: tb/tb_spart_img_loader.sv
// Self-checking bench for spart_img_loader with a behavioural SPART model.
module tb_spart_img_loader;

    localparam int         NUM_PIX = 784;
    localparam int         TO      = 300;
    localparam logic [7:0] HDR     = 8'hA5;
`ifdef SPART_IMG_BAUD_INIT_EN
    localparam int INIT_WR = 2;
`else
    localparam int INIT_WR = 0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic        rd;
        logic [1:0]  addr;
        logic [7:0]  data;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst_n, tx_q_full, frame_ack, result_vld;
    logic [3:0] result;
    wire  [7:0] databus;
    logic       iocs_n, iorw_n, img_we, frame_rdy, frame_err, rx_q_empty;
    logic [1:0] ioaddr;
    logic [9:0] img_addr;
    logic [7:0] img_wdata;

    // SPART RX queue model: bytes feed_mem[feed_rd .. feed_wr-1].
    logic [7:0] feed_mem [0:8191];
    int         feed_wr = 0;
    int         feed_rd = 0;

    strobe_t     strobe_log[$];
    logic [17:0] we_log[$];
    logic [7:0]  exp_q[$];
    int cyc = 0;
    int n_reads = 0, n_writes = 0, err_cnt = 0, rdy_cnt = 0;
    int gap_bad = 0, empty_rd_bad = 0, rdy_late_bad = 0, rdy_early_bad = 0;
    logic pop_due = 1'b0, prev_cs = 1'b1, last_we_prev = 1'b0;
    int n_assert = 0, n_fail = 0;

    assign rx_q_empty = (feed_rd == feed_wr);
    assign databus = (!iocs_n && iorw_n && ioaddr == 2'b00) ? feed_mem[feed_rd[12:0]] : 8'hzz;

    spart_img_loader #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iocs_n     (iocs_n),
        .iorw_n     (iorw_n),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .tx_q_full  (tx_q_full),
        .rx_q_empty (rx_q_empty),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_wdata  (img_wdata),
        .frame_rdy  (frame_rdy),
        .frame_ack  (frame_ack),
        .result_vld (result_vld),
        .result     (result),
        .frame_err  (frame_err)
    );

    // Clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus/image monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pop_due) feed_rd = feed_rd + 1;
        pop_due = 1'b0;
        if (!iocs_n) begin
            if (!prev_cs) gap_bad++;
            strobe_log.push_back('{cyc: 32'(cyc), rd: iorw_n, addr: ioaddr, data: databus});
            if (iorw_n) begin
                n_reads++;
                if (feed_rd == feed_wr) empty_rd_bad++;
                pop_due = 1'b1;
            end else begin
                n_writes++;
            end
        end
        prev_cs = iocs_n;
        if (img_we) we_log.push_back({img_addr, img_wdata});
        if (img_we && frame_rdy) rdy_early_bad++;
        if (last_we_prev && frame_rdy !== 1'b1) rdy_late_bad++;
        last_we_prev = img_we && (img_addr == 10'(NUM_PIX - 1));
        if (frame_err) err_cnt++;
        if (frame_rdy) rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        feed_mem[feed_wr[12:0]] = b;
        feed_wr = feed_wr + 1;
    endtask

    task automatic pulse_result(input logic [3:0] d);
        result     = d;
        result_vld = 1'b1;
        step(1);
        result_vld = 1'b0;
    endtask

    // Compare n image writes from we_log[base] with exp_q at addresses 0..n-1.
    task automatic check_frame(input string tag, input int base, input int n);
        check({tag, "_count"}, 32'(we_log.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < we_log.size(); i++)
            check({tag, "_pix"}, 32'(we_log[base + i]), 32'({10'(i), exp_q[i]}));
    endtask

    // First strobe after cycle c must be a TX write of d no later than cycle cmax.
    task automatic check_write(input string tag, input int c, input logic [7:0] d, input int cmax);
        int idx = -1;
        for (int i = 0; i < strobe_log.size(); i++)
            if (idx < 0 && int'(strobe_log[i].cyc) > c) idx = i;
        check({tag, "_present"}, 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
            check({tag, "_is_write"}, 32'(strobe_log[idx].rd), 32'd0);
            check({tag, "_addr"}, 32'(strobe_log[idx].addr), 32'd0);
            check({tag, "_data"}, 32'(strobe_log[idx].data), 32'(d));
            check({tag, "_time"}, 32'(int'(strobe_log[idx].cyc) <= cmax), 32'd1);
        end
    endtask

    initial begin
        int base, r0, w0, e0, k, c;
        logic [7:0] b;

        rst_n = 1'b0; tx_q_full = 1'b0; frame_ack = 1'b0; result_vld = 1'b0; result = 4'd0;
        step(3);
        check("rst_iocs_n", 32'(iocs_n), 32'd1);
        check("rst_iorw_n", 32'(iorw_n), 32'd1);
        check("rst_ioaddr", 32'(ioaddr), 32'd0);
        check("rst_img_we", 32'(img_we), 32'd0);
        check("rst_img_addr", 32'(img_addr), 32'd0);
        check("rst_img_wdata", 32'(img_wdata), 32'd0);
        check("rst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;

`ifdef SPART_IMG_BAUD_INIT_EN
        for (k = 0; k < 20 && strobe_log.size() < 2; k++) step(1);
        check("init_strobes", 32'(strobe_log.size() >= 2), 32'd1);
        if (strobe_log.size() >= 2) begin
            check("init_lo", 32'({strobe_log[0].rd, strobe_log[0].addr, strobe_log[0].data}), 32'({1'b0, 2'b10, 8'hB2}));
            check("init_hi", 32'({strobe_log[1].rd, strobe_log[1].addr, strobe_log[1].data}), 32'({1'b0, 2'b11, 8'h01}));
        end
`else
        step(10);
        check("no_init_strobes", 32'(strobe_log.size()), 32'd0);
`endif

        // Frame 1: junk, header, ramp pixels.
        base = we_log.size();
        exp_q.delete();
        push(8'h00); push(HDR);
        for (int i = 0; i < NUM_PIX; i++) begin
            push(i[7:0]);
            exp_q.push_back(i[7:0]);
        end
        for (k = 0; k < 5000 && !frame_rdy; k++) step(1);
        check("f1_frame_rdy", 32'(frame_rdy), 32'd1);
        check_frame("f1", base, NUM_PIX);
        check("f1_all_consumed", 32'(feed_wr - feed_rd), 32'd0);

        // HOLD: queued bytes must wait for the ack.
        r0 = n_reads;
        base = we_log.size();
        exp_q.delete();
        push(HDR);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
        end
        step(40);
        check("hold_no_reads", 32'(n_reads - r0), 32'd0);
        check("hold_rdy_held", 32'(frame_rdy), 32'd1);
        check("hold_bytes_waiting", 32'(feed_wr - feed_rd), 32'd4);
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;
        check("ack_drops_rdy", 32'(frame_rdy), 32'd0);

        // Frame 2: random pixels with random line gaps.
        for (int i = 3; i < NUM_PIX; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 6));
        end
        for (k = 0; k < 5000 && !frame_rdy; k++) step(1);
        check("f2_frame_rdy", 32'(frame_rdy), 32'd1);
        check_frame("f2", base, NUM_PIX);
        check("rdy_one_cycle_after_last_we", 32'(rdy_late_bad), 32'd0);
        check("rdy_not_with_we", 32'(rdy_early_bad), 32'd0);
        frame_ack = 1'b1;
        step(1);
        frame_ack = 1'b0;

        // Timeout on a partial frame.
        base = we_log.size();
        exp_q.delete();
        push(HDR);
        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
        end
        for (k = 0; k < 1000 && we_log.size() - base < 100; k++) step(1);
        e0 = err_cnt;
        r0 = rdy_cnt;
        step(TO - 10);
        check("to_no_early_err", 32'(err_cnt - e0), 32'd0);
        step(40);
        check("to_err_once", 32'(err_cnt - e0), 32'd1);
        check("to_no_frame_rdy", 32'(rdy_cnt - r0), 32'd0);
        check_frame("to_partial", base, 100);

        // Next header restarts at address 0.
        base = we_log.size();
        exp_q.delete();
        push(HDR);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            push(b);
            exp_q.push_back(b);
        end
        for (k = 0; k < 200 && we_log.size() - base < 5; k++) step(1);
        check_frame("restart", base, 5);
        e0 = err_cnt;
        step(TO + 40);
        check("restart_timeout_err", 32'(err_cnt - e0), 32'd1);

        // Result to TX with an idle bus: write one cycle after result_vld.
        c = cyc;
        w0 = n_writes;
        pulse_result(4'd3);
        step(5);
        check("tx_fast_count", 32'(n_writes - w0), 32'd1);
        check_write("tx_fast", c, 8'h33, c + 1);

        // TX stalled by a full queue while RX bytes keep arriving.
        tx_q_full = 1'b1;
        for (int i = 0; i < 30; i++) push(8'($urandom_range(0, 8'hA4)));
        w0 = n_writes;
        pulse_result(4'd7);
        step(20);
        check("tx_stall_no_write", 32'(n_writes - w0), 32'd0);
        c = cyc;
        tx_q_full = 1'b0;
        step(6);
        check("tx_stall_count", 32'(n_writes - w0), 32'd1);
        check_write("tx_beats_rx", c, 8'h37, c + 2);

        // Last result wins while one is pending.
        tx_q_full = 1'b1;
        w0 = n_writes;
        pulse_result(4'd4);
        step(3);
        pulse_result(4'd9);
        step(5);
        c = cyc;
        tx_q_full = 1'b0;
        step(6);
        check("tx_last_wins_count", 32'(n_writes - w0), 32'd1);
        check_write("tx_last_wins", c, 8'h39, c + 2);

        // Asynchronous reset in the middle of LOAD, with a result pending.
        for (k = 0; k < 200 && feed_rd != feed_wr; k++) step(1);
        tx_q_full = 1'b1;
        pulse_result(4'd5);
        base = we_log.size();
        push(HDR);
        for (int i = 0; i < 50; i++) push(8'($urandom_range(1, 255)));
        for (k = 0; k < 500 && we_log.size() - base < 20; k++) step(1);
        check("mid_load_reached", 32'(we_log.size() - base >= 20), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_iocs_n", 32'(iocs_n), 32'd1);
        check("arst_iorw_n", 32'(iorw_n), 32'd1);
        check("arst_ioaddr", 32'(ioaddr), 32'd0);
        check("arst_img_we", 32'(img_we), 32'd0);
        check("arst_img_addr", 32'(img_addr), 32'd0);
        check("arst_img_wdata", 32'(img_wdata), 32'd0);
        check("arst_frame_rdy", 32'(frame_rdy), 32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        step(2);
        tx_q_full = 1'b0;
        w0 = n_writes;
        rst_n = 1'b1;
        step(20);
        check("pending_dropped", 32'(n_writes - w0), 32'(INIT_WR));

        check("bus_idle_gap", 32'(gap_bad), 32'd0);
        check("read_only_when_nonempty", 32'(empty_rd_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
